// File: rtl/pir_sensor_frontend_if.sv
// Signal bundle between the raw PIR pins / system control and the conditioning front end.
// The bus carries plain levels only: there is no valid/ready handshake.
// Every input is sampled on each rising clk edge, and every output is a registered level.
interface pir_sensor_frontend_if;
    logic       enable;
    logic       raw_pir_1;
    logic       raw_pir_2;
    logic       raw_pir_3;
    logic       clear_latch;
    logic       pir_sensor_1;
    logic       pir_sensor_2;
    logic       pir_sensor_3;
    logic [2:0] zone_latched;
    logic [7:0] event_count;
    logic       holdoff_active;
    // Per-channel FSM state, two bits per channel, channel 1 in bits [1:0].
    logic [5:0] dbg_state;

    modport master (
        output enable, raw_pir_1, raw_pir_2, raw_pir_3, clear_latch,
        input  pir_sensor_1, pir_sensor_2, pir_sensor_3,
        input  zone_latched, event_count, holdoff_active, dbg_state
    );

    modport slave (
        input  enable, raw_pir_1, raw_pir_2, raw_pir_3, clear_latch,
        output pir_sensor_1, pir_sensor_2, pir_sensor_3,
        output zone_latched, event_count, holdoff_active, dbg_state
    );
endinterface

// File: rtl/pir_sensor_frontend.sv
// PIR conditioning front end: synchronise, qualify high/low runs, global re-trigger hold-off,
// and keep a sticky zone latch plus a saturating event counter for the display path.
module pir_sensor_frontend #(
    parameter int QUAL_CYCLES    = 4,
    parameter int RELEASE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pir_sensor_frontend_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_QUAL_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_QUAL_LO = 2'd3
    } state_t;

    // A run of N samples ends on the sample where the counter already holds N-1.
    localparam logic [7:0] QUAL_LAST    = 8'(QUAL_CYCLES - 1);
    localparam logic [7:0] RELEASE_LAST = 8'(RELEASE_CYCLES - 1);
    localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_CYCLES);
    localparam bit         QUAL_ONE     = (QUAL_CYCLES == 1);
    localparam bit         RELEASE_ONE  = (RELEASE_CYCLES == 1);

    logic [2:0] raw;
    logic [2:0] sync_meta;
    logic [2:0] sync_q;

    state_t     state_q [3];
    state_t     state_d [3];
    logic [7:0] cnt_q   [3];
    logic [7:0] cnt_d   [3];
    logic [2:0] out_q;
    logic [2:0] out_d;
    logic [2:0] rises;
    logic [2:0] falls;
    logic [7:0] hold_q;
    logic [7:0] hold_d;
    logic       hold_busy;
    logic [2:0] zone_q;
    logic [2:0] zone_d;
    logic [7:0] evt_q;
    logic [7:0] evt_d;
    logic [7:0] evt_base;

    assign raw = {bus.raw_pir_3, bus.raw_pir_2, bus.raw_pir_1};

    // Synchronisers run regardless of enable so a re-arm sees settled levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
        end
    end

    assign hold_busy = (hold_q != 8'd0);

    always_comb begin
        out_d = '0;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!bus.enable) begin
                state_d[i] = ST_LOW;
                cnt_d[i]   = 8'd0;
            end else begin
                case (state_q[i])
                    ST_LOW: begin
                        cnt_d[i] = 8'd0;
                        if (sync_q[i] && !hold_busy) begin
                            if (QUAL_ONE) begin
                                state_d[i] = ST_HIGH;
                            end else begin
                                state_d[i] = ST_QUAL_HI;
                                cnt_d[i]   = 8'd1;
                            end
                        end
                    end
                    ST_QUAL_HI: begin
                        if (!sync_q[i]) begin
                            state_d[i] = ST_LOW;
                            cnt_d[i]   = 8'd0;
                        end else if (cnt_q[i] >= QUAL_LAST) begin
                            state_d[i] = ST_HIGH;
                            cnt_d[i]   = 8'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                    ST_HIGH: begin
                        cnt_d[i] = 8'd0;
                        if (!sync_q[i]) begin
                            if (RELEASE_ONE) begin
                                state_d[i] = ST_LOW;
                            end else begin
                                state_d[i] = ST_QUAL_LO;
                                cnt_d[i]   = 8'd1;
                            end
                        end
                    end
                    ST_QUAL_LO: begin
                        if (sync_q[i]) begin
                            state_d[i] = ST_HIGH;
                            cnt_d[i]   = 8'd0;
                        end else if (cnt_q[i] >= RELEASE_LAST) begin
                            state_d[i] = ST_LOW;
                            cnt_d[i]   = 8'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = 8'd0;
                    end
                endcase
            end
            out_d[i] = (state_d[i] == ST_HIGH) || (state_d[i] == ST_QUAL_LO);
        end
    end

    assign rises = out_d & ~out_q;
    assign falls = out_q & ~out_d;

    // A forced drop from enable=0 clears the hold-off instead of starting one.
    always_comb begin
        hold_d = hold_q;
        if (!bus.enable) begin
            hold_d = 8'd0;
        end else if (|falls) begin
            hold_d = HOLDOFF_LOAD;
        end else if (hold_busy) begin
            hold_d = hold_q - 8'd1;
        end
    end

    // Clear applies first, so rises on the same edge survive into the fresh latch/count.
    always_comb begin
        evt_base = bus.clear_latch ? 8'd0 : evt_q;
        zone_d   = (bus.clear_latch ? 3'b000 : zone_q) | rises;
        evt_d    = evt_base;
        if ((|out_d) && !(|out_q) && (evt_base != 8'hFF)) begin
            evt_d = evt_base + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_LOW;
                cnt_q[i]   <= 8'd0;
            end
            out_q  <= '0;
            hold_q <= 8'd0;
            zone_q <= '0;
            evt_q  <= 8'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            out_q  <= out_d;
            hold_q <= hold_d;
            zone_q <= zone_d;
            evt_q  <= evt_d;
        end
    end

    assign bus.pir_sensor_1   = out_q[0];
    assign bus.pir_sensor_2   = out_q[1];
    assign bus.pir_sensor_3   = out_q[2];
    assign bus.zone_latched   = zone_q;
    assign bus.event_count    = evt_q;
    assign bus.holdoff_active = hold_busy;
    assign bus.dbg_state      = {state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_pir_sensor_frontend.sv
// Self-checking bench for pir_sensor_frontend with default parameters.
// Motion events are scoreboarded: expected {count, zone} is queued when stimulus is driven.
module tb_pir_sensor_frontend;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pir_sensor_frontend_if bus ();

  pir_sensor_frontend #(
    .QUAL_CYCLES    (4),
    .RELEASE_CYCLES (4),
    .HOLDOFF_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  exp_cnt  = 8'd0;
  logic [2:0]  exp_zone = 3'b000;

  logic        prev_any = 1'b0;
  logic        any_now;
  logic [10:0] exp_word;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_raw(input logic [2:0] v);
    bus.raw_pir_1 = v[0];
    bus.raw_pir_2 = v[1];
    bus.raw_pir_3 = v[2];
  endtask

  task automatic model_clear();
    exp_cnt  = 8'd0;
    exp_zone = 3'b000;
  endtask

  task automatic push_event(input logic [2:0] bits);
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    exp_zone = exp_zone | bits;
    exp_q.push_back({exp_cnt, exp_zone});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.enable      = 1'b0;
    bus.clear_latch = 1'b0;
    set_raw(3'b000);
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    tick(1);
  endtask

  task automatic wait_holdoff_clear(input string name);
    int guard;
    guard = 0;
    while (bus.holdoff_active && guard < 40) begin
      tick(1);
      guard++;
    end
    tests_run++;
    if (guard >= 40) begin
      tests_failed++;
      $display("FAIL %s: holdoff_active still 1 after %0d cycles, required 0", name, guard);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    any_now = bus.pir_sensor_1 | bus.pir_sensor_2 | bus.pir_sensor_3;
    if (rst) begin
      prev_any = 1'b0;
    end else begin
      if (any_now && !prev_any) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL event_unexpected: count=%0d zone=%b with no event expected",
                   bus.event_count, bus.zone_latched);
        end else begin
          exp_word = exp_q.pop_front();
          if ({bus.event_count, bus.zone_latched} !== exp_word) begin
            tests_failed++;
            $display("FAIL event_sb: count=%0d zone=%b, required count=%0d zone=%b",
                     bus.event_count, bus.zone_latched, exp_word[10:3], exp_word[2:0]);
          end
        end
      end
      prev_any = any_now;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b, required 000",
               {bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1});
    end
    tests_run++;
    if ({bus.event_count, bus.zone_latched, bus.holdoff_active} !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_state: count=%0d zone=%b holdoff=%b, required all 0",
               bus.event_count, bus.zone_latched, bus.holdoff_active);
    end
    tests_run++;
    if (bus.dbg_state !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_fsm: dbg_state=%b, required 000000", bus.dbg_state);
    end
  endtask

  task automatic test_glitch_and_assert();
    logic seen;
    bus.enable = 1'b1;
    set_raw(3'b001);
    tick(3);
    set_raw(3'b000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.pir_sensor_1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_reject: pir_sensor_1 rose=%b, required 0", seen);
    end
    push_event(3'b001);
    set_raw(3'b001);
    tick(5);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL assert_early: pir_sensor_1=%b after 5 edges, required 0", bus.pir_sensor_1);
    end
    tick(1);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL assert_latency: pir_sensor_1=%b after 6 edges, required 1", bus.pir_sensor_1);
    end
    tests_run++;
    if (bus.event_count !== 8'd1 || bus.zone_latched !== 3'b001) begin
      tests_failed++;
      $display("FAIL first_event: count=%0d zone=%b, required 1 001",
               bus.event_count, bus.zone_latched);
    end
    tick(14);
  endtask

  task automatic test_release_holdoff();
    int n;
    set_raw(3'b000);
    tick(5);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_early: pir_sensor_1=%b after 5 edges, required 1", bus.pir_sensor_1);
    end
    tick(1);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b0 || bus.holdoff_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_latency: pir1=%b holdoff=%b, required 0 1",
               bus.pir_sensor_1, bus.holdoff_active);
    end
    push_event(3'b010);
    set_raw(3'b010);
    n = 0;
    while (bus.holdoff_active && n < 100) begin
      n++;
      tick(1);
    end
    tests_run++;
    if (n != 16) begin
      tests_failed++;
      $display("FAIL holdoff_len: high for %0d cycles, required 16", n);
    end
    tick(3);
    tests_run++;
    if (bus.pir_sensor_2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL holdoff_block: pir_sensor_2=%b 3 edges after holdoff, required 0", bus.pir_sensor_2);
    end
    tick(1);
    tests_run++;
    if (bus.pir_sensor_2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_holdoff: pir_sensor_2=%b 4 edges after holdoff, required 1", bus.pir_sensor_2);
    end
    set_raw(3'b000);
    tick(6);
    wait_holdoff_clear("holdoff_wait_t2");
  endtask

  task automatic test_simultaneous();
    bus.clear_latch = 1'b1;
    tick(1);
    bus.clear_latch = 1'b0;
    model_clear();
    tests_run++;
    if (bus.event_count !== 8'd0 || bus.zone_latched !== 3'b000) begin
      tests_failed++;
      $display("FAIL clear_idle: count=%0d zone=%b, required 0 000",
               bus.event_count, bus.zone_latched);
    end
    push_event(3'b101);
    set_raw(3'b101);
    tick(5);
    tests_run++;
    if ({bus.pir_sensor_3, bus.pir_sensor_1} !== 2'b00) begin
      tests_failed++;
      $display("FAIL simul_early: pir3/pir1=%b, required 00", {bus.pir_sensor_3, bus.pir_sensor_1});
    end
    tick(1);
    tests_run++;
    if ({bus.pir_sensor_3, bus.pir_sensor_1} !== 2'b11 || bus.event_count !== 8'd1 ||
        bus.zone_latched !== 3'b101) begin
      tests_failed++;
      $display("FAIL simul_rise: pir3/pir1=%b count=%0d zone=%b, required 11 1 101",
               {bus.pir_sensor_3, bus.pir_sensor_1}, bus.event_count, bus.zone_latched);
    end
    // A second channel joining an active event sets its zone bit only.
    set_raw(3'b111);
    exp_zone = exp_zone | 3'b010;
    tick(6);
    tests_run++;
    if (bus.pir_sensor_2 !== 1'b1 || bus.event_count !== exp_cnt || bus.zone_latched !== exp_zone) begin
      tests_failed++;
      $display("FAIL join_no_count: pir2=%b count=%0d zone=%b, required 1 %0d %b",
               bus.pir_sensor_2, bus.event_count, bus.zone_latched, exp_cnt, exp_zone);
    end
    set_raw(3'b000);
    tick(6);
    tests_run++;
    if ({bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1} !== 3'b000 || bus.holdoff_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_release: outs=%b holdoff=%b, required 000 1",
               {bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1}, bus.holdoff_active);
    end
    wait_holdoff_clear("holdoff_wait_t3");
  endtask

  task automatic test_enable_drop();
    set_raw(3'b001);
    tick(4);
    tests_run++;
    if (bus.dbg_state[1:0] !== 2'd1) begin
      tests_failed++;
      $display("FAIL in_qual_hi: ch1 state=%0d, required 1", bus.dbg_state[1:0]);
    end
    bus.enable = 1'b0;
    tick(1);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b0 || bus.dbg_state[1:0] !== 2'd0 || bus.holdoff_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_qual: pir1=%b state=%0d holdoff=%b, required 0 0 0",
               bus.pir_sensor_1, bus.dbg_state[1:0], bus.holdoff_active);
    end
    tick(8);
    push_event(3'b001);
    bus.enable = 1'b1;
    tick(3);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rearm_early: pir_sensor_1=%b, required 0", bus.pir_sensor_1);
    end
    tick(1);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rearm_assert: pir_sensor_1=%b, required 1", bus.pir_sensor_1);
    end
    tick(3);
    bus.enable = 1'b0;
    tick(1);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b0 || bus.holdoff_active !== 1'b0 ||
        bus.event_count !== exp_cnt || bus.zone_latched !== exp_zone) begin
      tests_failed++;
      $display("FAIL drop_high: pir1=%b holdoff=%b count=%0d zone=%b, required 0 0 %0d %b",
               bus.pir_sensor_1, bus.holdoff_active, bus.event_count, bus.zone_latched,
               exp_cnt, exp_zone);
    end
    set_raw(3'b000);
    tick(3);
    bus.enable = 1'b1;
    tick(10);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b0 || bus.holdoff_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_drop: pir1=%b holdoff=%b, required 0 0",
               bus.pir_sensor_1, bus.holdoff_active);
    end
  endtask

  task automatic test_clear_saturation();
    int ch;
    logic [2:0] bits;
    set_raw(3'b010);
    tick(5);
    bus.clear_latch = 1'b1;
    model_clear();
    push_event(3'b010);
    tick(1);
    bus.clear_latch = 1'b0;
    tests_run++;
    if (bus.pir_sensor_2 !== 1'b1 || bus.zone_latched !== 3'b010 || bus.event_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL clear_same_edge: pir2=%b zone=%b count=%0d, required 1 010 1",
               bus.pir_sensor_2, bus.zone_latched, bus.event_count);
    end
    set_raw(3'b000);
    tick(6);
    wait_holdoff_clear("holdoff_wait_t5a");
    for (int k = 0; k < 300; k++) begin
      ch = $urandom_range(0, 2);
      bits = 3'b001 << ch;
      push_event(bits);
      set_raw(bits);
      tick($urandom_range(6, 10));
      set_raw(3'b000);
      tick(6);
      wait_holdoff_clear("holdoff_wait_t5b");
    end
    tests_run++;
    if (bus.event_count !== 8'd255 || bus.zone_latched !== exp_zone) begin
      tests_failed++;
      $display("FAIL saturation: count=%0d zone=%b, required 255 %b",
               bus.event_count, bus.zone_latched, exp_zone);
    end
  endtask

  task automatic test_async_reset();
    push_event(3'b001);
    set_raw(3'b001);
    tick(6);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset: pir_sensor_1=%b, required 1", bus.pir_sensor_1);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1} !== 3'b000 ||
        bus.event_count !== 8'd0 || bus.zone_latched !== 3'b000 || bus.holdoff_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: outs=%b count=%0d zone=%b holdoff=%b, required 000 0 000 0",
               {bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1}, bus.event_count,
               bus.zone_latched, bus.holdoff_active);
    end
    exp_q.delete();
    model_clear();
    tick(2);
    rst = 1'b0;
    push_event(3'b001);
    tick(5);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_early: pir_sensor_1=%b, required 0", bus.pir_sensor_1);
    end
    tick(1);
    tests_run++;
    if (bus.pir_sensor_1 !== 1'b1 || bus.event_count !== 8'd1 || bus.zone_latched !== 3'b001) begin
      tests_failed++;
      $display("FAIL post_reset_assert: pir1=%b count=%0d zone=%b, required 1 1 001",
               bus.pir_sensor_1, bus.event_count, bus.zone_latched);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.enable      = 1'b0;
    bus.clear_latch = 1'b0;
    set_raw(3'b000);
    test_reset();
    test_glitch_and_assert();
    test_release_holdoff();
    test_simultaneous();
    test_enable_drop();
    test_clear_saturation();
    test_async_reset();
    tick(2);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
